mac_drain: RTL and testbench
============================

Name: mac_drain

Overview:
- Result-readout engine for one row of MAC cells.
- On a `done` pulse it snapshots the NUM_COLS accumulators into a local buffer and pulses `mac_clear` back to the cells so the next computation can start.
- It then streams the buffered values out one per handshake on a valid/ready interface toward the writeback path.
- It is the reader side of the MAC accumulate outputs.

Parameters:
- NUM_COLS, 4, number of MAC cells (accumulators) drained per snapshot; must be at least 2.
- ACC_W, 32, accumulator width in bits; signed two's complement.
- RQ_SHIFT, 8, arithmetic right-shift amount used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done  in  1  single-cycle pulse: acc_in holds final values this cycle.
- acc_in  in  NUM_COLS*ACC_W  packed accumulators; column c occupies bits [c*ACC_W +: ACC_W].
- mac_clear  out  1  registered one-cycle clear pulse to all MAC cells.
- out_valid  out  1  out_data, out_idx and out_last are valid.
- out_ready  in  1  downstream accepts the current beat.
- out_data  out  ACC_W  buffered accumulator value (signed).
- out_idx  out  clog2(NUM_COLS)  column index of the current beat.
- out_last  out  1  high on the beat with out_idx == NUM_COLS-1.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky flag: a done pulse was dropped.

Behaviour:
- Reset (async assert, sync release): state=IDLE, buffer=0, idx=0. Outputs mac_clear=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0.
- States: IDLE, STREAM.
- IDLE, done=1:
  - Capture all acc_in columns into the buffer at that edge.
  - Go to STREAM with idx=0.
  - mac_clear=1 for exactly the next cycle.
- Latency: done in cycle T gives mac_clear=1 and out_valid=1 with out_idx=0 in cycle T+1. Combined with the MAC clear behaviour, the cell accumulators read 0 in cycle T+2.
- STREAM:
  - out_valid=1 continuously.
  - out_data = buffer[idx] (or the requantized value, see Optional Feature).
  - out_last = (idx == NUM_COLS-1).
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_ready=0, out_data, out_idx and out_last are held stable.
  - out_valid never drops before the transfer.
- On a transfer with out_last=0: idx increments.
- On a transfer with out_last=1:
  - If done=1 in the same cycle: recapture acc_in, set idx=0, stay in STREAM, pulse mac_clear. This is back-to-back operation with no bubble.
  - Otherwise: go to IDLE; out_valid=0 in the next cycle.
- done in STREAM when no last-beat transfer happens that cycle: ignored, buffer untouched, overrun set to 1. overrun is cleared only by reset.
- mac_clear is never high for two consecutive cycles unless two snapshots are accepted back-to-back.
- Buffer contents change only on an accepted capture.
- Reset mid-stream: the stream is aborted immediately, outputs return to reset values, and no mac_clear is issued.
- acc_in is sampled only on the capture edge; it may change freely at all other times.

Optional Feature:
- Macro: DRAIN_REQUANT_EN.
- Defined:
  - out_data = sign-extension to ACC_W of sat8(buffer[idx] >>> RQ_SHIFT).
  - sat8 clamps to the range [-128, 127].
  - The path is purely combinational from the buffer, so latency is unchanged.
- Undefined: out_data = buffer[idx] unmodified; RQ_SHIFT has no effect.

Decomposition:
- Package mac_drain_pkg holds:
  - the state enum type (IDLE, STREAM);
  - the default ACC_W constant;
  - the INT8_MIN/INT8_MAX constants;
  - a sat8 function.
- One sub-module is natural: drain_requant. It is combinational: ACC_W signed in, shift, saturate, sign-extend out. It is instantiated only under DRAIN_REQUANT_EN.

Test Plan:
1. Basic drain with no backpressure:
   - Stimulus: acc_in = {40, -7, 0, 1000} (col3..col0); done pulsed in cycle 5; out_ready=1 throughout.
   - Required: mac_clear=1 in cycle 6 only; beats in cycles 6-9 carry idx 0..3 and data 1000, 0, -7, 40; out_last=1 in cycle 9; busy=0 from cycle 10.
2. Backpressure:
   - Stimulus: same snapshot; out_ready=0 in cycles 7-9.
   - Required: idx 1 with data 0 held stable for cycles 7-9; transfer in cycle 10; total of 4 beats with no duplicates or drops.
3. Back-to-back snapshots:
   - Stimulus: a second done coincides with the last-beat transfer, with acc_in = {1, 2, 3, 4}.
   - Required: next cycle has out_idx=0 with data 4 and mac_clear=1; overrun stays 0.
4. Overrun:
   - Stimulus: done pulsed while idx=1 with out_ready=0.
   - Required: overrun=1 and remains 1; the streamed data is the original snapshot.
5. Reset mid-stream:
   - Stimulus: rst_n driven low at idx=2, then released.
   - Required: out_valid, mac_clear, busy and overrun all 0 immediately; the next done starts a fresh stream at idx 0.
6. DRAIN_REQUANT_EN with RQ_SHIFT=8:
   - Stimulus: accumulators {40000, -40000, 1280, -300}.
   - Required: out_data 127, -128, 5, -2 (as 32-bit sign-extended values).

Source files
------------

// File: rtl/mac_drain_pkg.sv
// mac_drain_pkg: shared types, constants and the int8 saturation helper
// used by mac_drain and drain_requant.
package mac_drain_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int INT8_MIN  = -128;
  localparam int INT8_MAX  = 127;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Clamp a signed value to the int8 range. Callers sign-extend to 64 bits
  // first, so any accumulator width up to 64 is covered.
  function automatic logic signed [7:0] sat8(input logic signed [63:0] v);
    if (v > 64'(INT8_MAX))      return 8'(INT8_MAX);
    else if (v < 64'(INT8_MIN)) return 8'(INT8_MIN);
    else                        return v[7:0];
  endfunction

endpackage

// File: rtl/drain_requant.sv
// drain_requant: combinational requantizer.
//   din  : signed accumulator value (ACC_W)
//   dout : sat8(din >>> RQ_SHIFT), sign-extended back to ACC_W
module drain_requant
  import mac_drain_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int RQ_SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [ACC_W-1:0] dout
);

  logic signed [ACC_W-1:0] sh;
  logic signed [7:0]       q8;

  assign sh   = din >>> RQ_SHIFT;
  assign q8   = sat8(64'(sh));
  assign dout = ACC_W'(q8);

endmodule

// File: rtl/mac_drain.sv
// mac_drain: result-readout engine for one row of MAC cells.
// On done it snapshots all accumulators, pulses mac_clear, then streams the
// snapshot one column per valid/ready handshake.
// Optional feature: define DRAIN_REQUANT_EN to output int8-saturated,
// RQ_SHIFT-scaled values instead of raw accumulators.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   done, acc_in   snapshot request and packed accumulators (col c at [c*ACC_W +: ACC_W])
//   mac_clear      one-cycle clear pulse to the cells after each capture
//   out_valid/out_ready/out_data/out_idx/out_last  result stream
//   busy           not IDLE
//   overrun        sticky: a done was dropped while streaming
module mac_drain
  import mac_drain_pkg::*;
#(
  parameter int  NUM_COLS = 4,
  parameter int  ACC_W    = ACC_W_DEF,
  parameter int  RQ_SHIFT = 8,
  localparam int IDX_W    = $clog2(NUM_COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done,
  input  logic [NUM_COLS*ACC_W-1:0] acc_in,
  output logic                      mac_clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  state_e                         state;
  logic [NUM_COLS-1:0][ACC_W-1:0] buf_q;
  logic [IDX_W-1:0]               idx;
  logic                           xfer, last_xfer, capture, drop;
  logic [ACC_W-1:0]               raw;

  assign out_valid = (state == STREAM);
  assign busy      = (state != IDLE);
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == IDX_W'(NUM_COLS - 1));
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && out_last;

  // A done is accepted from IDLE, or in STREAM only when it coincides with
  // the last beat leaving (back-to-back, no bubble). Anything else is lost.
  assign capture = done && ((state == IDLE) || last_xfer);
  assign drop    = done && (state == STREAM) && !last_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      buf_q     <= '0;
      idx       <= '0;
      mac_clear <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mac_clear <= capture;
      if (capture) buf_q   <= acc_in;
      if (drop)    overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (done) begin
            state <= STREAM;
            idx   <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_last) begin
              idx <= '0;
              if (!done) state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign raw = buf_q[idx];

`ifdef DRAIN_REQUANT_EN
  drain_requant #(
    .ACC_W    (ACC_W),
    .RQ_SHIFT (RQ_SHIFT)
  ) u_rq (
    .din  (raw),
    .dout (out_data)
  );
`else
  // Raw pass-through; RQ_SHIFT only matters in the requantizing build.
  logic [31:0] rq_shift_unused;
  assign rq_shift_unused = 32'(RQ_SHIFT);
  assign out_data        = raw;
`endif

endmodule

// File: tb/tb_mac_drain.sv
module tb_mac_drain;

  localparam int NC = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n, done, out_ready;
  logic [NC*AW-1:0] acc_in;
  logic            mac_clear, out_valid, out_last, busy, overrun;
  logic [AW-1:0]   out_data;
  logic [1:0]      out_idx;

  always #5 clk = ~clk;

  mac_drain #(.NUM_COLS(NC), .ACC_W(AW), .RQ_SHIFT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .acc_in    (acc_in),
    .mac_clear (mac_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exq[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)",
                  nm, $signed(act), act, $signed(exp), exp);
  endtask

  // Expected output value for a raw accumulator.
  function automatic logic [31:0] model(input int v);
`ifdef DRAIN_REQUANT_EN
    int s;
    s = v >>> 8;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
`else
    return v;
`endif
  endfunction

  function automatic logic [NC*AW-1:0] pack(input int c3, input int c2, input int c1, input int c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push_raw(input int d0, input int d1, input int d2, input int d3);
    exq.push_back('{idx: 2'd0, data: d0, last: 1'b0});
    exq.push_back('{idx: 2'd1, data: d1, last: 1'b0});
    exq.push_back('{idx: 2'd2, data: d2, last: 1'b0});
    exq.push_back('{idx: 2'd3, data: d3, last: 1'b1});
  endtask

  task automatic push_snap(input int c3, input int c2, input int c1, input int c0);
    push_raw(model(c0), model(c1), model(c2), model(c3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented beat is compared with the queue head;
  // the head is retired only when the beat actually transfers.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected beat: idx=%0d data=%0d, required no beat", out_idx, $signed(out_data));
      end else begin
        chk("beat idx",  32'(out_idx),  32'(exq[0].idx));
        chk("beat data", out_data,      exq[0].data);
        chk("beat last", 32'(out_last), 32'(exq[0].last));
        if (out_ready) void'(exq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; done = 1'b0; out_ready = 1'b1; acc_in = '0;
    repeat (3) tick();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst mac_clear", 32'(mac_clear), 0);
    chk("rst out_data",  out_data,       0);
    chk("rst out_idx",   32'(out_idx),   0);
    chk("rst out_last",  32'(out_last),  0);
    chk("rst busy",      32'(busy),      0);
    chk("rst overrun",   32'(overrun),   0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: basic drain, no backpressure
    acc_in = pack(40, -7, 0, 1000);
    push_snap(40, -7, 0, 1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    acc_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("t1 mac_clear T+1", 32'(mac_clear), 1);
    chk("t1 out_valid T+1", 32'(out_valid), 1);
    chk("t1 out_idx T+1",   32'(out_idx),   0);
    tick();
    chk("t1 mac_clear T+2", 32'(mac_clear), 0);
    tick(); tick();
    chk("t1 out_last idx3", 32'(out_last),  1);
    tick();
    chk("t1 busy after",    32'(busy),      0);
    chk("t1 valid after",   32'(out_valid), 0);
    tick();

    // 2: backpressure on idx 1
    acc_in = pack(40, -7, 0, 1000);
    push_snap(40, -7, 0, 1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("t2 held idx", 32'(out_idx), 1);
    chk("t2 held data", out_data, model(0));
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t2 busy after", 32'(busy), 0);
    chk("t2 queue drained", 32'(exq.size()), 0);
    tick();

    // 3: back-to-back snapshot on the last beat
    acc_in = pack(40, -7, 0, 1000);
    push_snap(40, -7, 0, 1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick(); tick();
    acc_in = pack(1, 2, 3, 4);
    push_snap(1, 2, 3, 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t3 mac_clear", 32'(mac_clear), 1);
    chk("t3 out_idx",   32'(out_idx),   0);
    chk("t3 out_data",  out_data,       model(4));
    chk("t3 overrun",   32'(overrun),   0);
    repeat (4) tick();
    chk("t3 busy after",    32'(busy),    0);
    chk("t3 overrun after", 32'(overrun), 0);
    tick();

    // 4: overrun while stalled at idx 1
    acc_in = pack(40, -7, 0, 1000);
    push_snap(40, -7, 0, 1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    out_ready = 1'b0;
    acc_in = pack(9, 9, 9, 9);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4 overrun set", 32'(overrun),   1);
    chk("t4 no mac_clear", 32'(mac_clear), 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t4 overrun sticky", 32'(overrun), 1);
    chk("t4 busy after",     32'(busy),    0);

    // 5: reset mid-stream at idx 2
    acc_in = pack(40, -7, 0, 1000);
    push_snap(40, -7, 0, 1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick();
    chk("t5 at idx2", 32'(out_idx), 2);
    rst_n = 1'b0;
    #1;
    chk("t5 rst out_valid", 32'(out_valid), 0);
    chk("t5 rst mac_clear", 32'(mac_clear), 0);
    chk("t5 rst busy",      32'(busy),      0);
    chk("t5 rst overrun",   32'(overrun),   0);
    exq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5 no clear after rst", 32'(mac_clear), 0);
    acc_in = pack(1, 2, 3, 4);
    push_snap(1, 2, 3, 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t5 fresh idx",   32'(out_idx),   0);
    chk("t5 fresh clear", 32'(mac_clear), 1);
    repeat (4) tick();

    // 6: saturation vectors (raw in the default build)
    acc_in = pack(40000, -40000, 1280, -300);
`ifdef DRAIN_REQUANT_EN
    push_raw(-2, 5, -128, 127);
`else
    push_raw(-300, 1280, -40000, 40000);
`endif
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (5) tick();
    chk("final queue empty", 32'(exq.size()), 0);
    chk("final busy",        32'(busy),       0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
